// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward-select
// codes, register-index width and the per-stage shadow tag layout.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W      = 5;
  localparam int CNT_W      = 16;
  localparam int NUM_STAGES = 3;

  // Indices into the shadow-tag array, youngest first.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     reg_write;
    logic     load;
  } stage_tag_t;

  // A stage already qualified as a legal forwarding source.
  typedef struct packed {
    logic     ok;
    reg_idx_t dest;
  } fwd_cand_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): ID-stage instruction info, hazard requests and control outputs.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic             id_valid;
  reg_idx_t         id_rs;
  reg_idx_t         id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  reg_idx_t         id_dest;
  logic             id_reg_write;
  logic             id_load;
  logic             branch_taken;
  logic             mem_wait;
  logic             stall_count_load;
  logic [CNT_W-1:0] stall_count_val;

  logic             pc_load_en;
  logic             if_id_load_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_load, branch_taken, mem_wait,
           stall_count_load, stall_count_val,
    input  pc_load_en, if_id_load_en, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_a_sel, fwd_b_sel, state, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_load, branch_taken, mem_wait,
           stall_count_load, stall_count_val,
    output pc_load_en, if_id_load_en, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_a_sel, fwd_b_sel, state, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding source picker for one ID operand: youngest qualified stage whose
// destination matches the operand wins, otherwise the register file.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  reg_idx_t  operand_i,
  input  fwd_cand_t ex_i,
  input  fwd_cand_t mem_i,
  input  fwd_cand_t wb_i,
  output fwd_sel_e  sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_i.ok && ex_i.dest == operand_i) begin
      sel_o = FWD_EX;
    end else if (mem_i.ok && mem_i.dest == operand_i) begin
      sel_o = FWD_MEM;
    end else if (wb_i.ok && wb_i.dest == operand_i) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze and
// ID-operand forwarding. Define DELAY_SLOT_EN to execute the branch delay slot.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  stage_tag_t       tag_q [NUM_STAGES];
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  stage_tag_t id_tag;
  fwd_cand_t  cand [NUM_STAGES];
  fwd_sel_e   fwd_a, fwd_b;
  logic       load_use;
  logic       pc_load_en, if_id_load_en, if_id_flush, id_ex_bubble, pipe_freeze;

  always_comb begin
    load_use = 1'b0;
    if (tag_q[STG_EX].valid && tag_q[STG_EX].load && tag_q[STG_EX].dest != '0) begin
      load_use = hz.id_valid &&
                 ((hz.id_uses_rs && hz.id_rs == tag_q[STG_EX].dest) ||
                  (hz.id_uses_rt && hz.id_rt == tag_q[STG_EX].dest));
    end
  end

  // A load sitting in EX has no result yet; the stall covers that case.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      cand[i].ok   = tag_q[i].valid && tag_q[i].reg_write && tag_q[i].dest != '0;
      cand[i].dest = tag_q[i].dest;
    end
    cand[STG_EX].ok = cand[STG_EX].ok && !tag_q[STG_EX].load;
  end

  fwd_select u_fwd_a (
    .operand_i (hz.id_rs),
    .ex_i      (cand[STG_EX]),
    .mem_i     (cand[STG_MEM]),
    .wb_i      (cand[STG_WB]),
    .sel_o     (fwd_a)
  );

  fwd_select u_fwd_b (
    .operand_i (hz.id_rt),
    .ex_i      (cand[STG_EX]),
    .mem_i     (cand[STG_MEM]),
    .wb_i      (cand[STG_WB]),
    .sel_o     (fwd_b)
  );

  // Controls act in the same cycle as the condition, so they are decoded
  // combinationally; reset forces them to the free-running values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the if/else chain can leave one unassigned and infer a latch.
    pc_load_en    = 1'b1;
    if_id_load_en = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_freeze   = 1'b0;
    state_d       = ST_RUN;
    stall_count_d = stall_count_q;
    if (!reset) begin
      if (hz.mem_wait) begin
        pc_load_en    = 1'b0;
        if_id_load_en = 1'b0;
        pipe_freeze   = 1'b1;
        state_d       = ST_FREEZE;
      end else if (load_use) begin
        pc_load_en    = 1'b0;
        if_id_load_en = 1'b0;
        id_ex_bubble  = 1'b1;
        state_d       = ST_STALL;
        if (stall_count_q != '1) begin
          stall_count_d = stall_count_q + CNT_W'(1);
        end
      end else if (hz.branch_taken) begin
`ifdef DELAY_SLOT_EN
        state_d     = ST_RUN;
`else
        if_id_flush = 1'b1;
        state_d     = ST_FLUSH;
`endif
      end
    end
    if (hz.stall_count_load) begin
      stall_count_d = hz.stall_count_val;
    end
  end

  always_comb begin
    id_tag.valid     = hz.id_valid && !id_ex_bubble;
    id_tag.dest      = hz.id_dest;
    id_tag.reg_write = hz.id_reg_write;
    id_tag.load      = hz.id_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow tags are a handful of flops, not a RAM, so the whole
      // array is cleared; stale valid bits would otherwise fake hazards.
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      tag_q         <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments let each stage read its neighbour's
      // pre-edge value, which is what makes the shift order-independent.
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      if (!pipe_freeze) begin
        tag_q[STG_EX]  <= id_tag;
        tag_q[STG_MEM] <= tag_q[STG_EX];
        tag_q[STG_WB]  <= tag_q[STG_MEM];
      end
    end
  end

  assign hz.pc_load_en    = pc_load_en;
  assign hz.if_id_load_en = if_id_load_en;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.pipe_freeze   = pipe_freeze;
  assign hz.fwd_a_sel     = fwd_a;
  assign hz.fwd_b_sel     = fwd_b;
  assign hz.state         = state_q;
  assign hz.stall_count   = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// random ID traffic, compared against an in-flight instruction queue model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

`ifdef DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: instructions in flight after ID, youngest (EX) at index 0.
  typedef struct {bit v; int dest; bit rw; bit ld;} instr_t;
  instr_t inflight[$];
  int     m_state;
  int     m_count;

  bit s_valid, s_urs, s_urt, s_rw, s_ld, s_br, s_mw, s_pre;
  int s_rs, s_rt, s_dest, s_pre_val;

  task automatic model_reset();
    inflight = {};
    for (int i = 0; i < 3; i++) inflight.push_back('{v: 0, dest: 0, rw: 0, ld: 0});
    m_state = 0;
    m_count = 0;
  endtask

  function automatic int src_for(input int r);
    for (int i = 0; i < 3; i++) begin
      if (inflight[i].v && inflight[i].rw && inflight[i].dest != 0 && inflight[i].dest == r &&
          !(i == 0 && inflight[i].ld)) return i + 1;
    end
    return 0;
  endfunction

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit rw, input bit ld);
    s_valid = v; s_rs = rs; s_rt = rt; s_urs = urs; s_urt = urt;
    s_dest = dest; s_rw = rw; s_ld = ld;
    s_br = 0; s_mw = 0; s_pre = 0; s_pre_val = 0;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply();
    hz.id_valid         = s_valid;
    hz.id_rs            = 5'(s_rs);
    hz.id_rt            = 5'(s_rt);
    hz.id_uses_rs       = s_urs;
    hz.id_uses_rt       = s_urt;
    hz.id_dest          = 5'(s_dest);
    hz.id_reg_write     = s_rw;
    hz.id_load          = s_ld;
    hz.branch_taken     = s_br;
    hz.mem_wait         = s_mw;
    hz.stall_count_load = s_pre;
    hz.stall_count_val  = 16'(s_pre_val);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pc_load_en"},    32'(hz.pc_load_en),    32'd1);
    check({tag, ".if_id_load_en"}, 32'(hz.if_id_load_en), 32'd1);
    check({tag, ".if_id_flush"},   32'(hz.if_id_flush),   32'd0);
    check({tag, ".id_ex_bubble"},  32'(hz.id_ex_bubble),  32'd0);
    check({tag, ".pipe_freeze"},   32'(hz.pipe_freeze),   32'd0);
    check({tag, ".fwd_a_sel"},     32'(hz.fwd_a_sel),     32'd0);
    check({tag, ".fwd_b_sel"},     32'(hz.fwd_b_sel),     32'd0);
    check({tag, ".state"},         32'(hz.state),         32'd0);
    check({tag, ".stall_count"},   32'(hz.stall_count),   32'd0);
  endtask

  // One clock: drive at negedge, check the same-cycle controls, then check
  // registered state after the edge.
  task automatic step(input string tag);
    bit lu;
    int e_pc, e_ifid, e_fl, e_bub, e_frz, nst;
    @(negedge clk);
    apply();
    #1;
    lu = s_valid && inflight[0].v && inflight[0].ld && inflight[0].dest != 0 &&
         ((s_urs && s_rs == inflight[0].dest) || (s_urt && s_rt == inflight[0].dest));
    e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; e_frz = 0; nst = 0;
    if (s_mw) begin
      e_pc = 0; e_ifid = 0; e_frz = 1; nst = 3;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; nst = 1;
    end else if (s_br) begin
      e_fl = DELAY_SLOT ? 0 : 1;
      nst  = DELAY_SLOT ? 0 : 2;
    end
    check({tag, ".pc_load_en"},    32'(hz.pc_load_en),    e_pc);
    check({tag, ".if_id_load_en"}, 32'(hz.if_id_load_en), e_ifid);
    check({tag, ".if_id_flush"},   32'(hz.if_id_flush),   e_fl);
    check({tag, ".id_ex_bubble"},  32'(hz.id_ex_bubble),  e_bub);
    check({tag, ".pipe_freeze"},   32'(hz.pipe_freeze),   e_frz);
    check({tag, ".fwd_a_sel"},     32'(hz.fwd_a_sel),     src_for(s_rs));
    check({tag, ".fwd_b_sel"},     32'(hz.fwd_b_sel),     src_for(s_rt));
    @(posedge clk);
    #1;
    if (!s_mw) begin
      inflight.push_front('{v: s_valid && !lu, dest: s_dest, rw: s_rw, ld: s_ld});
      void'(inflight.pop_back());
    end
    if (s_pre) m_count = s_pre_val;
    else if (!s_mw && lu && m_count < 65535) m_count++;
    m_state = nst;
    check({tag, ".state"},       32'(hz.state),       m_state);
    check({tag, ".stall_count"}, 32'(hz.stall_count), m_count);
  endtask

  initial begin
    // Reset with hazard requests asserted: outputs must still sit at idle values.
    reset = 1'b1;
    set_id(1, 5, 5, 1, 1, 5, 1, 1);
    s_br = 1; s_mw = 1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    set_idle();
    apply();
    reset = 1'b0;
    model_reset();

    // lw $5 ; add $6,$5,$1 -> one bubble, then forwarded from the load.
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  step("lw5");
    set_id(1, 5, 1, 1, 1, 6, 1, 0);  step("add_stall");
    check("lu.count_one", 32'(hz.stall_count), 32'd1);
    set_id(1, 5, 1, 1, 1, 6, 1, 0);  step("add_go");

    // Forwarding distance 1, 2, 3 and $0.
    for (int gap = 0; gap < 3; gap++) begin
      repeat (3) begin set_idle(); step("drain"); end
      set_id(1, 1, 2, 1, 1, 3, 1, 0);  step("add3");
      for (int k = 0; k < gap; k++) begin set_idle(); step("gap"); end
      set_id(1, 3, 4, 1, 1, 7, 1, 0);  step($sformatf("sub_gap%0d", gap));
    end
    set_id(1, 1, 2, 1, 1, 0, 1, 0);  step("add0");
    set_id(1, 0, 0, 1, 1, 7, 1, 0);  step("use0");

    // Branch alone.
    set_idle(); s_br = 1;  step("branch");
    set_idle();            step("after_branch");

    // Freeze for three cycles on top of a pending load-use.
    set_id(1, 0, 0, 0, 0, 7, 1, 1);  step("lw7");
    for (int k = 0; k < 3; k++) begin
      set_id(1, 0, 7, 0, 1, 8, 1, 0); s_br = 1; s_mw = 1;  step("freeze");
    end
    set_id(1, 0, 7, 0, 1, 8, 1, 0); s_br = 1;  step("unfreeze_stall");
    set_id(1, 0, 7, 0, 1, 8, 1, 0); s_br = 1;  step("branch_replay");

    // Saturation of the stall counter.
    set_idle(); s_pre = 1; s_pre_val = 16'hFFFF;  step("preload");
    set_id(1, 0, 0, 0, 0, 9, 1, 1);  step("lw9");
    set_id(1, 9, 0, 1, 0, 10, 1, 0); step("sat_stall");
    check("sat.count", 32'(hz.stall_count), 32'hFFFF);

    // Reset in the middle of a stall cycle.
    set_id(1, 0, 0, 0, 0, 5, 1, 1);  step("lw5b");
    set_id(1, 5, 0, 1, 0, 6, 1, 0);
    @(negedge clk);
    apply();
    #1;
    check("mid.bubble", 32'(hz.id_ex_bubble), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    set_idle();
    apply();
    reset = 1'b0;
    model_reset();
    set_id(1, 5, 0, 1, 0, 6, 1, 0);  step("post_reset");

    // Random traffic over a small register set to provoke frequent matches.
    for (int n = 0; n < 3000; n++) begin
      set_id(($urandom % 8) != 0, $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 2,
             $urandom % 4, ($urandom % 4) != 0, ($urandom % 3) == 0);
      s_br = ($urandom % 8) == 0;
      s_mw = ($urandom % 10) == 0;
      if (($urandom % 400) == 0) begin
        s_pre = 1;
        s_pre_val = 16'hFFF8 + ($urandom % 8);
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
